wbu_stage: RTL and testbench
============================

WBU_STAGE -- requirements
Module: wbu_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 SHALL have parameter RD_W, default 5: register-index width.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 valid_i / ready_o  in / out  1 / 1  LSU-to-WBU handshake; a transfer occurs when both are 1 on a clock edge.
REQ-006 reg_wena_i  in  1  instruction writes rd.
REQ-007 reg_sel_i  in  2  write-data select: 00 ALUout, 01 mem_rdata, 10 pc+4, 11 imm.
REQ-008 mem_rdata_i, ALUout_i, pc_i, imm_i, src1_i, inst_i  in  XLEN each  payload from LSU.
REQ-009 rf_wena_o, rf_waddr_o, rf_wdata_o  out  1 / RD_W / XLEN  register-file write port.
REQ-010 commit_valid_o, commit_pc_o, commit_inst_o  out  1 / XLEN / XLEN  retire pulse to IFU/trace.
REQ-011 busy_o, busy_rd_o  out  1 / RD_W  pending-write scoreboard for the decode hazard check.
REQ-012 instret_o  out  64  retired-instruction count; present only with WBU_INSTRET_EN.

Function
REQ-013 SHALL hold one entry in a payload register; states are IDLE (empty) and HOLD (full).
REQ-014 ready_o SHALL be 1 in IDLE and 0 in HOLD; capture requires valid_i & ready_o.
REQ-015 IDLE->HOLD on capture; HOLD->IDLE unconditionally on the next edge; a capture in HOLD is impossible, so throughput is one instruction per 2 cycles.
REQ-016 In HOLD: rf_wena_o = held reg_wena & (rd != 0); rf_waddr_o = held inst[11:7]; rf_wdata_o per the held reg_sel.
REQ-017 pc+4 SHALL wrap modulo 2^32 (pc 0xFFFFFFFC gives 0x00000000).
REQ-018 In HOLD, commit_valid_o SHALL be 1 for exactly one cycle with the held pc/inst, including when no register write occurs.
REQ-019 In IDLE: rf_wena_o = 0, commit_valid_o = 0, and data outputs hold their last values.
REQ-020 Write latency from the capture edge to rf_wena_o high SHALL be 0 cycles; the register file samples the write on the following edge.
REQ-021 busy_o SHALL be 1 and busy_rd_o SHALL be rd in HOLD when rf_wena_o = 1; otherwise busy_o = 0 and busy_rd_o = 0.
REQ-022 valid_i = 1 with X payload while ready_o = 0 SHALL have no effect.
REQ-023 rd = x0 with reg_wena_i = 1 SHALL commit without writing.

Reset
REQ-024 rst_i high at an edge SHALL force IDLE; all outputs read 0 the next cycle (ready_o = 1).
REQ-025 Reset asserted in HOLD SHALL discard the held entry: no write and no commit.
REQ-026 rst_i SHALL override a simultaneous capture.

Configuration
REQ-027 With WBU_INSTRET_EN defined: a 64-bit counter, reset to 0, increments on every commit_valid_o cycle, wraps 2^64-1 -> 0, and drives instret_o; the new value is visible the cycle after the commit.
REQ-028 Without WBU_INSTRET_EN: no counter logic and no instret_o port.

Structure
REQ-029 The shared package SHALL hold the reg_sel encodings (SEL_ALU, SEL_MEM, SEL_PC4, SEL_IMM), the state enum (IDLE, HOLD), and RD_LSB = 7.
REQ-030 One sub-module, wbu_wdata_mux, SHALL be used: a combinational 4:1 select plus the pc+4 adder.
REQ-031 Payload and state registers SHALL live in wbu_stage; no other sub-modules.

Verification
REQ-032 Load: reg_sel 01, inst rd = 5, mem_rdata 0xDEADBEEF -> the next cycle shows rf_wena 1, waddr 5, wdata 0xDEADBEEF, commit_valid 1, ready_o 0.
REQ-033 JAL: reg_sel 10, pc 0xFFFFFFFC, rd = 1 -> wdata 0x00000000; commit_pc 0xFFFFFFFC.
REQ-034 Store (reg_wena 0), then ALU op to x0 with ALUout 0x12345678 -> two commit pulses, rf_wena stays 0, busy_o stays 0.
REQ-035 valid_i held high for 10 cycles with distinct imm payloads (reg_sel 11) -> exactly 5 commits in order, ready_o toggles 1/0.
REQ-036 Capture, then rst_i high during HOLD -> no commit pulse, ready_o 1 after reset, instret_o 0.
REQ-037 With WBU_INSTRET_EN: 3 commits -> instret_o = 3; counter preloaded to 0xFFFFFFFFFFFFFFFF plus 1 commit -> 0.

Source files
------------

// File: rtl/wbu_stage_pkg.sv
// Shared definitions for the write-back stage: write-data select codes,
// stage state encoding and the bit position of rd inside an instruction.
package wbu_stage_pkg;

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_MEM = 2'b01,
    SEL_PC4 = 2'b10,
    SEL_IMM = 2'b11
  } reg_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int RD_LSB = 7;

endpackage

// File: rtl/wbu_wdata_mux.sv
// Write-back data select: 4:1 choice between ALU result, load data,
// link address (pc+4, wraps modulo 2^XLEN) and immediate.
module wbu_wdata_mux #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_sel,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_mem,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_wdata
);
  import wbu_stage_pkg::*;

  logic [XLEN-1:0] w_pc4;

  assign w_pc4 = i_pc + XLEN'(4);

  always_comb begin
    o_wdata = i_alu;
    case (i_sel)
      SEL_ALU: o_wdata = i_alu;
      SEL_MEM: o_wdata = i_mem;
      SEL_PC4: o_wdata = w_pc4;
      SEL_IMM: o_wdata = i_imm;
      default: o_wdata = i_alu;
    endcase
  end

endmodule

// File: rtl/wbu_stage.sv
// Single-entry write-back stage: captures one LSU result, writes the register
// file and pulses commit in the following cycle. Optional retired-instruction
// counter on instret_o is built only when WBU_INSTRET_EN is defined.
module wbu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            reg_wena_i,
  input  logic [1:0]      reg_sel_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [XLEN-1:0] ALUout_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] inst_i,
  output logic            rf_wena_o,
  output logic [RD_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            commit_valid_o,
  output logic [XLEN-1:0] commit_pc_o,
  output logic [XLEN-1:0] commit_inst_o,
  output logic            busy_o,
  output logic [RD_W-1:0] busy_rd_o
`ifdef WBU_INSTRET_EN
  ,
  output logic [63:0]     instret_o
`endif
);
  import wbu_stage_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid_i and ready_o
  // are both 1; ready_o depends only on state, never on valid_i.

  state_e          r_state;
  state_e          w_state_nxt;

  logic            r_reg_wena;
  logic [1:0]      r_reg_sel;
  logic [XLEN-1:0] r_mem_rdata;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_inst;

  logic            w_capture;
  logic            w_hold;
  logic [RD_W-1:0] w_rd;
  logic [XLEN-1:0] w_wdata;
  logic            w_unused_src1;

  // src1 travels with the payload but the write-back path has no use for it.
  assign w_unused_src1 = ^src1_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) w_state_nxt = HOLD;
      end
      HOLD: begin
        ready_o     = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        ready_o     = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_capture = valid_i & ready_o;

  // Payload only loads on a real capture, so data outputs keep their last
  // values through IDLE and an X payload offered while full is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_reg_wena  <= 1'b0;
      r_reg_sel   <= 2'b00;
      r_mem_rdata <= '0;
      r_alu       <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_inst      <= '0;
    end else if (w_capture) begin
      r_reg_wena  <= reg_wena_i;
      r_reg_sel   <= reg_sel_i;
      r_mem_rdata <= mem_rdata_i;
      r_alu       <= ALUout_i;
      r_pc        <= pc_i;
      r_imm       <= imm_i;
      r_inst      <= inst_i;
    end
  end

  wbu_wdata_mux #(
    .XLEN(XLEN)
  ) u_wdata_mux (
    .i_sel   (r_reg_sel),
    .i_alu   (r_alu),
    .i_mem   (r_mem_rdata),
    .i_pc    (r_pc),
    .i_imm   (r_imm),
    .o_wdata (w_wdata)
  );

  // A reset arriving while an entry is held discards it, so the write and
  // commit strobes are suppressed for that cycle.
  assign w_hold = (r_state == HOLD) & ~rst_i;
  assign w_rd   = r_inst[RD_LSB +: RD_W];

  assign rf_wena_o      = w_hold & r_reg_wena & (w_rd != '0);
  assign rf_waddr_o     = w_rd;
  assign rf_wdata_o     = w_wdata;
  assign commit_valid_o = w_hold;
  assign commit_pc_o    = r_pc;
  assign commit_inst_o  = r_inst;
  assign busy_o         = rf_wena_o;
  assign busy_rd_o      = rf_wena_o ? w_rd : '0;

`ifdef WBU_INSTRET_EN
  logic [63:0] r_instret;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instret <= '0;
    end else if (commit_valid_o) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret_o = r_instret;
`else
  // No retired-instruction counter in this build.
`endif

endmodule

// File: tb/tb_wbu_stage.sv
// Self-checking bench for wbu_stage: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_wbu_stage;

  typedef struct {
    logic        wena;
    logic [1:0]  sel;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] inst;
  } txn_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        reg_wena;
  logic [1:0]  reg_sel;
  logic [31:0] mem_rdata, alu_out, pc, imm, src1, inst;

  logic        ready_o, rf_wena_o, commit_valid_o, busy_o;
  logic [4:0]  rf_waddr_o, busy_rd_o;
  logic [31:0] rf_wdata_o, commit_pc_o, commit_inst_o;
  logic [63:0] instret_o;

  always #5 clk = ~clk;

  wbu_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid),
    .ready_o        (ready_o),
    .reg_wena_i     (reg_wena),
    .reg_sel_i      (reg_sel),
    .mem_rdata_i    (mem_rdata),
    .ALUout_i       (alu_out),
    .pc_i           (pc),
    .imm_i          (imm),
    .src1_i         (src1),
    .inst_i         (inst),
    .rf_wena_o      (rf_wena_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .commit_valid_o (commit_valid_o),
    .commit_pc_o    (commit_pc_o),
    .commit_inst_o  (commit_inst_o),
    .busy_o         (busy_o),
`ifdef WBU_INSTRET_EN
    .busy_rd_o      (busy_rd_o),
    .instret_o      (instret_o)
`else
    .busy_rd_o      (busy_rd_o)
`endif
  );

`ifndef WBU_INSTRET_EN
  assign instret_o = 64'd0;
`endif

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  bit          m_full = 1'b0;
  txn_t        m_p;
  logic [63:0] m_instret = 64'd0;
  logic [63:0] exp_q[$];
  int          n_commits = 0;
  int          n_writes = 0;
  int          n_busy = 0;
  logic [31:0] seen_wdata[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_wdata(input txn_t t);
    case (t.sel)
      2'b00:   return t.alu;
      2'b01:   return t.mem;
      2'b10:   return t.pc + 32'd4;
      default: return t.imm;
    endcase
  endfunction

  // Transaction model: an offered item is taken only when the stage is empty,
  // and it is retired in the very next cycle unless reset intervenes.
  always @(posedge clk) begin
    if (rst) begin
      m_full    = 1'b0;
      m_p       = '{1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      m_instret = 64'd0;
      exp_q.delete();
    end else if (m_full) begin
      m_full    = 1'b0;
      m_instret = m_instret + 64'd1;
    end else if (valid) begin
      m_full = 1'b1;
      m_p    = '{reg_wena, reg_sel, mem_rdata, alu_out, pc, imm, inst};
      exp_q.push_back({pc, inst});
    end
  end

  // Compare process: every output against the model on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic       e_commit;
      logic [4:0] e_rd;
      logic       e_wena;
      e_commit = m_full & ~rst;
      e_rd     = m_p.inst[11:7];
      e_wena   = e_commit & m_p.wena & (e_rd != 5'd0);
      chk("ready", {63'd0, ready_o}, {63'd0, ~m_full});
      chk("commit_valid", {63'd0, commit_valid_o}, {63'd0, e_commit});
      chk("rf_wena", {63'd0, rf_wena_o}, {63'd0, e_wena});
      chk("rf_waddr", {59'd0, rf_waddr_o}, {59'd0, e_rd});
      chk("rf_wdata", {32'd0, rf_wdata_o}, {32'd0, model_wdata(m_p)});
      chk("commit_pc", {32'd0, commit_pc_o}, {32'd0, m_p.pc});
      chk("commit_inst", {32'd0, commit_inst_o}, {32'd0, m_p.inst});
      chk("busy", {63'd0, busy_o}, {63'd0, e_wena});
      chk("busy_rd", {59'd0, busy_rd_o}, {59'd0, e_wena ? e_rd : 5'd0});
`ifdef WBU_INSTRET_EN
      chk("instret", instret_o, m_instret);
`endif
      if (commit_valid_o === 1'b1) begin
        n_commits++;
        seen_wdata.push_back(rf_wdata_o);
        if (exp_q.size() == 0) begin
          chk("commit_order_empty", {commit_pc_o, commit_inst_o}, 64'd0);
        end else begin
          chk("commit_order", {commit_pc_o, commit_inst_o}, exp_q.pop_front());
        end
      end
      if (rf_wena_o === 1'b1) n_writes++;
      if (busy_o === 1'b1) n_busy++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic [1:0] s, input logic [31:0] m,
                       input logic [31:0] a, input logic [31:0] p,
                       input logic [31:0] i, input logic [31:0] ins, input logic v);
    reg_wena  = w;
    reg_sel   = s;
    mem_rdata = m;
    alu_out   = a;
    pc        = p;
    imm       = i;
    inst      = ins;
    src1      = $urandom;
    valid     = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid = 1'b0;
    end
  endtask

  // Offers one item for one cycle; returns just after the capture edge.
  task automatic send(input logic w, input logic [1:0] s, input logic [31:0] m,
                      input logic [31:0] a, input logic [31:0] p,
                      input logic [31:0] i, input logic [31:0] ins);
    @(posedge clk);
    #1;
    drive(w, s, m, a, p, i, ins, 1'b1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic clear_counts();
    n_commits = 0;
    n_writes  = 0;
    n_busy    = 0;
    seen_wdata.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_wdata", {32'd0, rf_wdata_o}, 64'd0);
    chk("rst_commit_pc", {32'd0, commit_pc_o}, 64'd0);
    chk("rst_instret", instret_o, 64'd0);

    // load to x5
    idle(2);
    send(1'b1, 2'b01, 32'hDEADBEEF, 32'h11111111, 32'h00000100, 32'h0, 32'h00002283);
    @(negedge clk);
    chk("load_wena", {63'd0, rf_wena_o}, 64'd1);
    chk("load_waddr", {59'd0, rf_waddr_o}, 64'd5);
    chk("load_wdata", {32'd0, rf_wdata_o}, 64'hDEADBEEF);
    chk("load_commit", {63'd0, commit_valid_o}, 64'd1);
    chk("load_ready", {63'd0, ready_o}, 64'd0);

    // jal x1 at the top of the address space
    idle(2);
    send(1'b1, 2'b10, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h000000EF);
    @(negedge clk);
    chk("jal_wdata", {32'd0, rf_wdata_o}, 64'h0);
    chk("jal_commit_pc", {32'd0, commit_pc_o}, 64'hFFFFFFFC);
    chk("jal_waddr", {59'd0, rf_waddr_o}, 64'd1);

    // store, then ALU op targeting x0
    idle(3);
    clear_counts();
    send(1'b0, 2'b00, 32'h0, 32'hAAAA5555, 32'h00000200, 32'h0, 32'h00112023);
    idle(2);
    send(1'b1, 2'b00, 32'h0, 32'h12345678, 32'h00000204, 32'h0, 32'h00000033);
    idle(3);
    chk("st_x0_commits", 64'(n_commits), 64'd2);
    chk("st_x0_writes", 64'(n_writes), 64'd0);
    chk("st_x0_busy", 64'(n_busy), 64'd0);

    // valid held high for 10 cycles
    idle(3);
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 2'b11, $urandom, $urandom, 32'h00002000 + 32'(4 * k),
            32'h10000000 + 32'(k), 32'h00000393, 1'b1);
    end
    idle(4);
    chk("stream_commits", 64'(n_commits), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("stream_wdata", {32'd0, (i < seen_wdata.size()) ? seen_wdata[i] : 32'hFFFFFFFF},
          {32'd0, 32'h10000000 + 32'(2 * i)});
    end

    // reset while holding an entry
    idle(3);
    clear_counts();
    send(1'b1, 2'b00, 32'h0, 32'hCAFEF00D, 32'h00000300, 32'h0, 32'h00000393);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rsthold_commits", 64'(n_commits), 64'd0);
    chk("rsthold_ready", {63'd0, ready_o}, 64'd1);
    chk("rsthold_instret", instret_o, 64'd0);

`ifdef WBU_INSTRET_EN
    for (int k = 0; k < 3; k++) begin
      idle(2);
      send(1'b1, 2'b11, 32'h0, 32'h0, 32'h400 + 32'(4 * k), 32'(k), 32'h00000393);
    end
    idle(2);
    @(negedge clk);
    chk("instret_3", instret_o, 64'd3);
`endif

    // random traffic
    repeat (400) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 49) == 0);
      if (m_full && $urandom_range(0, 1) == 1) begin
        reg_wena  = 1'bx;
        reg_sel   = 2'bxx;
        mem_rdata = 'x;
        alu_out   = 'x;
        pc        = 'x;
        imm       = 'x;
        inst      = 'x;
        valid     = 1'b1;
      end else begin
        logic [31:0] r_inst_v;
        r_inst_v = $urandom;
        if ($urandom_range(0, 3) == 0) r_inst_v[11:7] = 5'd0;
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC),
              $urandom, r_inst_v, ($urandom_range(0, 2) != 0));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
